// File: rtl/xgemac_rx_pkt_source.sv
// Packet-aware receive FIFO: words are written freely, but reads only start once
// a complete packet (eop written) is stored, so the consumer never sees a partial packet.
module xgemac_rx_pkt_source #(
  parameter int DATA_WIDTH = 64,
  parameter int MOD_WIDTH  = 3,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_val,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic [MOD_WIDTH-1:0]  wr_mod,
  input  logic                  wr_err,
  output logic                  wr_full,
  input  logic                  pkt_rx_ren,
  output logic                  pkt_rx_avail,
  output logic                  pkt_rx_val,
  output logic [DATA_WIDTH-1:0] pkt_rx_data,
  output logic                  pkt_rx_sop,
  output logic                  pkt_rx_eop,
  output logic [MOD_WIDTH-1:0]  pkt_rx_mod,
  output logic                  pkt_rx_err,
  output logic                  rx_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DATA_WIDTH + MOD_WIDTH + 3;

  logic [WW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         word_cnt;
  logic [CW-1:0]         pkt_cnt;
  logic [CW-1:0]         pkt_cnt_next;
  logic [CW-1:0]         word_cnt_next;

  logic                  wr_accept;
  logic                  pop;
  logic                  pkt_in;
  logic                  pkt_out;
  logic [WW-1:0]         wr_word;
  logic [WW-1:0]         rd_word;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_sop;
  logic                  rd_eop;
  logic [MOD_WIDTH-1:0]  rd_mod;
  logic                  rd_err;

  assign wr_full   = (word_cnt == CW'(FIFO_DEPTH));
  assign wr_accept = wr_val && !wr_full;
  // Only complete packets are readable, so a nonzero packet count gates every pop.
  assign pop       = pkt_rx_ren && (pkt_cnt != '0);

  assign wr_word = {wr_data, wr_sop, wr_eop, wr_mod, wr_err};
  assign rd_word = mem[rd_ptr];
  assign rd_data = rd_word[WW-1 -: DATA_WIDTH];
  assign rd_sop  = rd_word[MOD_WIDTH+2];
  assign rd_eop  = rd_word[MOD_WIDTH+1];
  assign rd_mod  = rd_word[MOD_WIDTH:1];
  assign rd_err  = rd_word[0];

  assign pkt_in  = wr_accept && wr_eop;
  assign pkt_out = pop && rd_eop;

  always_comb begin
    pkt_cnt_next = pkt_cnt;
    unique case ({pkt_in, pkt_out})
      2'b10:   pkt_cnt_next = pkt_cnt + CW'(1);
      2'b01:   pkt_cnt_next = pkt_cnt - CW'(1);
      default: pkt_cnt_next = pkt_cnt;
    endcase
  end

  always_comb begin
    word_cnt_next = word_cnt;
    unique case ({wr_accept, pop})
      2'b10:   word_cnt_next = word_cnt + CW'(1);
      2'b01:   word_cnt_next = word_cnt - CW'(1);
      default: word_cnt_next = word_cnt;
    endcase
  end

  // Storage array carries no reset; validity is tracked entirely by the counters.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      word_cnt <= word_cnt_next;
      pkt_cnt  <= pkt_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_rx_val   <= 1'b0;
      pkt_rx_avail <= 1'b0;
      pkt_rx_data  <= '0;
      pkt_rx_sop   <= 1'b0;
      pkt_rx_eop   <= 1'b0;
      pkt_rx_mod   <= '0;
      pkt_rx_err   <= 1'b0;
      rx_ovf       <= 1'b0;
    end else begin
      pkt_rx_avail <= (pkt_cnt_next != '0);
      rx_ovf       <= wr_val && wr_full;
      pkt_rx_val   <= pop;
      if (pop) begin
        pkt_rx_data <= rd_data;
        pkt_rx_sop  <= rd_sop;
        pkt_rx_eop  <= rd_eop;
        pkt_rx_mod  <= rd_mod;
        pkt_rx_err  <= rd_err;
      end else begin
        // Data and mod hold their last value; the framing strobes are forced low.
        pkt_rx_sop  <= 1'b0;
        pkt_rx_eop  <= 1'b0;
        pkt_rx_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xgemac_rx_pkt_source.sv
// Bench for xgemac_rx_pkt_source: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_xgemac_rx_pkt_source;

  localparam int DW = 64;
  localparam int MW = 3;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_val;
  logic [DW-1:0] wr_data;
  logic          wr_sop;
  logic          wr_eop;
  logic [MW-1:0] wr_mod;
  logic          wr_err;
  logic          wr_full;
  logic          pkt_rx_ren;
  logic          pkt_rx_avail;
  logic          pkt_rx_val;
  logic [DW-1:0] pkt_rx_data;
  logic          pkt_rx_sop;
  logic          pkt_rx_eop;
  logic [MW-1:0] pkt_rx_mod;
  logic          pkt_rx_err;
  logic          rx_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xgemac_rx_pkt_source #(.DATA_WIDTH(DW), .MOD_WIDTH(MW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_val(wr_val), .wr_data(wr_data), .wr_sop(wr_sop), .wr_eop(wr_eop),
    .wr_mod(wr_mod), .wr_err(wr_err), .wr_full(wr_full),
    .pkt_rx_ren(pkt_rx_ren), .pkt_rx_avail(pkt_rx_avail), .pkt_rx_val(pkt_rx_val),
    .pkt_rx_data(pkt_rx_data), .pkt_rx_sop(pkt_rx_sop), .pkt_rx_eop(pkt_rx_eop),
    .pkt_rx_mod(pkt_rx_mod), .pkt_rx_err(pkt_rx_err), .rx_ovf(rx_ovf)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [DW-1:0] d;
    logic          s;
    logic          e;
    logic [MW-1:0] m;
    logic          er;
  } word_t;

  word_t         mq[$];
  int            m_pkts;
  logic          e_val, e_sop, e_eop, e_err, e_avail, e_ovf;
  logic [DW-1:0] e_data;
  logic [MW-1:0] e_mod;

  task automatic model_reset();
    mq.delete();
    m_pkts = 0;
    e_val = 0; e_sop = 0; e_eop = 0; e_err = 0; e_avail = 0; e_ovf = 0;
    e_data = '0; e_mod = '0;
  endtask

  task automatic model_step();
    bit full;
    word_t w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    full  = (mq.size() == DEPTH);
    e_ovf = wr_val && full;
    if (pkt_rx_ren && m_pkts != 0) begin
      w = mq.pop_front();
      e_val = 1; e_data = w.d; e_sop = w.s; e_eop = w.e; e_mod = w.m; e_err = w.er;
      if (w.e) m_pkts--;
    end else begin
      e_val = 0; e_sop = 0; e_eop = 0; e_err = 0;
    end
    if (wr_val && !full) begin
      w.d = wr_data; w.s = wr_sop; w.e = wr_eop; w.m = wr_mod; w.er = wr_err;
      mq.push_back(w);
      if (wr_eop) m_pkts++;
    end
    e_avail = (m_pkts != 0);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("val",   pkt_rx_val,   e_val);
    chk("data",  pkt_rx_data,  e_data);
    chk("sop",   pkt_rx_sop,   e_sop);
    chk("eop",   pkt_rx_eop,   e_eop);
    chk("mod",   pkt_rx_mod,   e_mod);
    chk("err",   pkt_rx_err,   e_err);
    chk("avail", pkt_rx_avail, e_avail);
    chk("ovf",   rx_ovf,       e_ovf);
    chk("full",  wr_full,      mq.size() == DEPTH);
  endtask

  // One clock: model advances on the same edge as the DUT, outputs compared 1ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    wr_val = 0; wr_data = '0; wr_sop = 0; wr_eop = 0; wr_mod = '0; wr_err = 0;
    pkt_rx_ren = 0;
  endtask

  task automatic wr(logic [DW-1:0] d, logic s, logic e, logic [MW-1:0] m);
    wr_val = 1; wr_data = d; wr_sop = s; wr_eop = e; wr_mod = m; wr_err = 0;
  endtask

  task automatic drain(int n);
    idle();
    pkt_rx_ren = 1;
    for (int i = 0; i < n; i++) tick();
    idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit in_pkt;
    int pw, pr;
    idle();
    rst_n = 0;
    model_reset();
    #1;
    chk("reset_full", wr_full, 0);
    chk("reset_avail", pkt_rx_avail, 0);
    tick(); tick();
    #2 rst_n = 1;
    tick();

    // 3-word packet then read
    wr(64'h11, 1, 0, 0); tick();
    wr(64'h22, 0, 0, 0); tick();
    chk("s1_avail_before_eop", pkt_rx_avail, 0);
    wr(64'h33, 0, 1, 5); tick();
    chk("s1_avail_after_eop", pkt_rx_avail, 1);
    idle(); pkt_rx_ren = 1;
    tick();
    chk("s1_w0_data", pkt_rx_data, 64'h11);
    chk("s1_w0_sop", pkt_rx_sop, 1);
    tick();
    chk("s1_w1_data", pkt_rx_data, 64'h22);
    tick();
    chk("s1_w2_data", pkt_rx_data, 64'h33);
    chk("s1_w2_eop", pkt_rx_eop, 1);
    chk("s1_w2_mod", pkt_rx_mod, 5);
    chk("s1_avail_after_pop", pkt_rx_avail, 0);
    idle(); tick();
    chk("s1_val_low", pkt_rx_val, 0);
    chk("s1_data_hold", pkt_rx_data, 64'h33);

    // read requested on an incomplete packet
    wr(64'hA1, 1, 0, 0); pkt_rx_ren = 1; tick();
    wr(64'hA2, 0, 0, 0); tick();
    chk("s2_no_pop", pkt_rx_val, 0);
    wr(64'hA3, 0, 1, 2); tick();
    chk("s2_no_pop_eop", pkt_rx_val, 0);
    wr_val = 0; tick();
    chk("s2_first_read", pkt_rx_data, 64'hA1);
    chk("s2_first_val", pkt_rx_val, 1);
    drain(4);

    // fill to full, overflow, one pop
    for (int i = 0; i < DEPTH; i++) begin
      wr(64'h1000 + i, 1, 1, 0); tick();
    end
    chk("s3_full", wr_full, 1);
    wr(64'hDEAD, 1, 1, 0); tick();
    chk("s3_ovf", rx_ovf, 1);
    idle(); tick();
    chk("s3_ovf_pulse", rx_ovf, 0);
    pkt_rx_ren = 1; tick();
    chk("s3_not_full", wr_full, 0);
    chk("s3_pop_data", pkt_rx_data, 64'h1000);
    drain(DEPTH + 2);

    // back-to-back packets, no bubble
    wr(64'hB0, 1, 0, 0); tick();
    wr(64'hB1, 0, 1, 1); tick();
    wr(64'hC0, 1, 1, 7); tick();
    idle(); pkt_rx_ren = 1;
    tick(); chk("s4_v0", pkt_rx_val, 1);
    tick(); chk("s4_v1", pkt_rx_val, 1);
    tick(); chk("s4_v2", pkt_rx_val, 1); chk("s4_d2", pkt_rx_data, 64'hC0);
    tick(); chk("s4_v3", pkt_rx_val, 0);
    idle(); tick();

    // simultaneous eop write and eop pop with one packet stored
    wr(64'hD0, 1, 1, 0); tick();
    wr(64'hE0, 1, 0, 0); tick();
    wr(64'hE1, 0, 1, 3); pkt_rx_ren = 1; tick();
    chk("s5_avail", pkt_rx_avail, 1);
    chk("s5_data", pkt_rx_data, 64'hD0);
    drain(4);

    // reset in the middle of a read
    wr(64'hF0, 1, 0, 0); tick();
    wr(64'hF1, 0, 0, 0); tick();
    wr(64'hF2, 0, 0, 0); tick();
    wr(64'hF3, 0, 1, 4); tick();
    idle(); pkt_rx_ren = 1; tick(); tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("s6_rst_val", pkt_rx_val, 0);
    chk("s6_rst_data", pkt_rx_data, 0);
    chk("s6_rst_avail", pkt_rx_avail, 0);
    chk("s6_rst_full", wr_full, 0);
    idle(); tick();
    rst_n = 1;
    tick();
    chk("s6_avail_after", pkt_rx_avail, 0);
    wr(64'h77, 1, 0, 0); tick();
    wr(64'h78, 0, 1, 6); tick();
    idle(); pkt_rx_ren = 1; tick();
    chk("s6_read0", pkt_rx_data, 64'h77);
    chk("s6_read0_sop", pkt_rx_sop, 1);
    tick();
    chk("s6_read1", pkt_rx_data, 64'h78);
    idle(); tick();

    // randomized traffic, phases biased toward filling or draining
    in_pkt = 0;
    for (int ph = 0; ph < 6; ph++) begin
      pw = (ph % 2 == 0) ? 90 : 30;
      pr = (ph % 2 == 0) ? 20 : 80;
      for (int c = 0; c < 500; c++) begin
        wr_val = ($urandom_range(99) < pw);
        wr_data = {$urandom, $urandom};
        wr_sop = !in_pkt;
        wr_eop = ($urandom_range(3) == 0);
        wr_mod = MW'($urandom);
        wr_err = ($urandom_range(7) == 0);
        pkt_rx_ren = ($urandom_range(99) < pr);
        if (wr_val && !wr_full) in_pkt = !wr_eop;
        tick();
      end
    end
    drain(DEPTH + 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
